fwrisc_fetch: RTL and testbench

- Instruction-fetch stage of the fwrisc core; sits directly upstream of fwrisc_decode and drives its fetch_valid/instr/instr_c inputs.
- Issues word reads on the instruction bus for the PC supplied by the execute stage.
- Handles halfword-aligned PCs: it reassembles 32-bit instructions that straddle a word boundary and expands RV32C instructions via a sub-module.
- Keeps a one-word buffer so sequential compressed instructions in the same word need no new bus read.

---
 rtl/fwrisc_fetch_pkg.sv | 16 +
 rtl/fwrisc_fetch_if.sv | 10 +
 rtl/fwrisc_c_decode.sv | 99 +++++++++
 rtl/fwrisc_fetch.sv | 138 +++++++++++++
 tb/tb_fwrisc_fetch.sv | 270 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/fwrisc_fetch_pkg.sv
// Shared types and constants for the fwrisc instruction-fetch stage.
package fwrisc_fetch_pkg;

    typedef enum logic [1:0] {
        WAIT_PC = 2'd0,
        FETCH1  = 2'd1,
        FETCH2  = 2'd2,
        VALID   = 2'd3
    } fetch_state_e;

    // Low two bits of a halfword that mark the start of a 32-bit instruction
    localparam logic [1:0] OP32 = 2'b11;

    localparam logic [31:0] RESET_VEC_DEFAULT = 32'h8000_0000;

endpackage

// File: rtl/fwrisc_fetch_if.sv
// Instruction bus: word-aligned read request, data returned in the accepting cycle.
interface fwrisc_fetch_if;
    logic [31:0] iaddr;
    logic        ivalid;
    logic        iready;
    logic [31:0] idata;

    modport master (output iaddr, output ivalid, input iready, input idata);
    modport slave  (input iaddr, input ivalid, output iready, output idata);
endinterface

// File: rtl/fwrisc_c_decode.sv
// Combinational RV32C to RV32I expander. Illegal or unsupported encodings
// (including the FP forms) produce 32'h0 and raise illegal.
module fwrisc_c_decode
    import fwrisc_fetch_pkg::*;
(
    input  logic [15:0] instr_i,
    output logic [31:0] instr_o,
    output logic        illegal
);
    logic [15:0] c;
    logic [4:0]  rd, rs2, rdp, rs1p;
    logic [11:0] imm6;
    logic [19:0] jimm;
    logic [31:0] ex;
    logic        ill;

    assign c    = instr_i;
    assign rd   = c[11:7];
    assign rs2  = c[6:2];
    assign rdp  = {2'b01, c[4:2]};
    assign rs1p = {2'b01, c[9:7]};
    assign imm6 = {{6{c[12]}}, c[12], c[6:2]};
    // JAL immediate field layout imm[20|10:1|11|19:12] from the CJ format
    assign jimm = {c[12], c[8], c[10], c[9], c[6], c[7], c[2], c[11],
                   c[5], c[4], c[3], c[12], {8{c[12]}}};

    // Expand by quadrant and funct3
    always_comb begin
        ex  = '0;
        ill = 1'b0;
        case ({c[1:0], c[15:13]})
            5'b00_000: begin // c.addi4spn
                ex  = {2'b00, c[10:7], c[12:11], c[5], c[6], 2'b00, 5'd2, 3'b000, rdp, 7'b0010011};
                ill = (c[12:5] == 8'd0);
            end
            5'b00_010: ex = {5'b0, c[5], c[12:10], c[6], 2'b00, rs1p, 3'b010, rdp, 7'b0000011};
            5'b00_110: ex = {5'b0, c[5], c[12], rdp, rs1p, 3'b010, c[11:10], c[6], 2'b00, 7'b0100011};
            5'b01_000: ex = {imm6, rd, 3'b000, rd, 7'b0010011};
            5'b01_001: ex = {jimm, 5'd1, 7'b1101111};
            5'b01_010: ex = {imm6, 5'd0, 3'b000, rd, 7'b0010011};
            5'b01_011: begin
                ill = ({c[12], c[6:2]} == 6'd0);
                if (rd == 5'd2) // c.addi16sp
                    ex = {{3{c[12]}}, c[4], c[3], c[5], c[2], c[6], 4'b0000, 5'd2, 3'b000, 5'd2, 7'b0010011};
                else            // c.lui
                    ex = {{15{c[12]}}, c[6:2], rd, 7'b0110111};
            end
            5'b01_100: begin
                case (c[11:10])
                    2'b00: begin ex = {7'b0000000, c[6:2], rs1p, 3'b101, rs1p, 7'b0010011}; ill = c[12]; end
                    2'b01: begin ex = {7'b0100000, c[6:2], rs1p, 3'b101, rs1p, 7'b0010011}; ill = c[12]; end
                    2'b10: ex = {imm6, rs1p, 3'b111, rs1p, 7'b0010011};
                    2'b11: begin
                        ill = c[12];
                        case (c[6:5])
                            2'b00: ex = {7'b0100000, rdp, rs1p, 3'b000, rs1p, 7'b0110011};
                            2'b01: ex = {7'b0000000, rdp, rs1p, 3'b100, rs1p, 7'b0110011};
                            2'b10: ex = {7'b0000000, rdp, rs1p, 3'b110, rs1p, 7'b0110011};
                            2'b11: ex = {7'b0000000, rdp, rs1p, 3'b111, rs1p, 7'b0110011};
                        endcase
                    end
                endcase
            end
            5'b01_101: ex = {jimm, 5'd0, 7'b1101111};
            5'b01_110: ex = {c[12], {3{c[12]}}, c[6], c[5], c[2], 5'd0, rs1p, 3'b000,
                             c[11], c[10], c[4], c[3], c[12], 7'b1100011};
            5'b01_111: ex = {c[12], {3{c[12]}}, c[6], c[5], c[2], 5'd0, rs1p, 3'b001,
                             c[11], c[10], c[4], c[3], c[12], 7'b1100011};
            5'b10_000: begin ex = {7'b0000000, c[6:2], rd, 3'b001, rd, 7'b0010011}; ill = c[12]; end
            5'b10_010: begin
                ex  = {4'b0, c[3:2], c[12], c[6:4], 2'b00, 5'd2, 3'b010, rd, 7'b0000011};
                ill = (rd == 5'd0);
            end
            5'b10_100: begin
                if (!c[12]) begin
                    if (rs2 == 5'd0) begin // c.jr
                        ex  = {12'b0, rd, 3'b000, 5'd0, 7'b1100111};
                        ill = (rd == 5'd0);
                    end else begin         // c.mv
                        ex = {7'b0, rs2, 5'd0, 3'b000, rd, 7'b0110011};
                    end
                end else begin
                    if (rs2 == 5'd0) begin
                        if (rd == 5'd0) ex = 32'h0010_0073;                         // c.ebreak
                        else            ex = {12'b0, rd, 3'b000, 5'd1, 7'b1100111}; // c.jalr
                    end else begin         // c.add
                        ex = {7'b0, rs2, rd, 3'b000, rd, 7'b0110011};
                    end
                end
            end
            5'b10_110: ex = {4'b0, c[8:7], c[12], rs2, 5'd2, 3'b010, c[11:9], 2'b00, 7'b0100011};
            default:   ill = 1'b1;
        endcase
    end

    assign illegal = ill || (c[1:0] == OP32);
    assign instr_o = illegal ? 32'h0 : ex;

endmodule

// File: rtl/fwrisc_fetch.sv
// Instruction fetch: word reads for the exec-supplied PC, halfword-aligned
// reassembly of straddling instructions, RV32C expansion and a one-word
// buffer so back-to-back compressed instructions skip the bus.
module fwrisc_fetch
    import fwrisc_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_VEC         = RESET_VEC_DEFAULT,
    parameter bit          ENABLE_COMPRESSED = 1'b1
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [31:0]        next_pc,
    input  logic               next_pc_valid,
    fwrisc_fetch_if.master     bus,
    output logic               fetch_valid,
    input  logic               decode_ready,
    output logic [31:0]        instr,
    output logic               instr_c
);
    fetch_state_e state, state_nxt;

    // PC held as word index plus halfword select; bit 0 is never stored
    logic [29:0] pc_word;
    logic        pc_half;
    logic [29:0] pc_word_inc;

    logic        buf_valid;
    logic [29:0] buf_tag;
    logic [31:0] buf_data;
    logic        buf_hit;

    logic [15:0] hi_half;
    logic [31:0] word;
    logic [15:0] half;
    logic        is_c;
    logic [31:0] c_expanded;
    logic        c_illegal;
    logic        f1_done, f2_done;
    logic        ivalid_c;
    logic [31:0] iaddr_c;

    assign pc_word_inc = pc_word + 30'd1;
    assign buf_hit     = buf_valid && (buf_tag == pc_word);
    assign word        = buf_hit ? buf_data : bus.idata;
    assign half        = pc_half ? word[31:16] : word[15:0];
    assign is_c        = ENABLE_COMPRESSED && (half[1:0] != OP32);
    assign f1_done     = (state == FETCH1) && (buf_hit || bus.iready);
    assign f2_done     = (state == FETCH2) && bus.iready;

    fwrisc_c_decode u_c_decode (
        .instr_i (half),
        .instr_o (c_expanded),
        .illegal (c_illegal)
    );

    // Next-state and bus request
    always_comb begin
        state_nxt = state;
        ivalid_c  = 1'b0;
        iaddr_c   = {pc_word, 2'b00};
        case (state)
            WAIT_PC: if (next_pc_valid) state_nxt = FETCH1;
            FETCH1: begin
                ivalid_c = !buf_hit;
                if (f1_done) state_nxt = (!is_c && pc_half) ? FETCH2 : VALID;
            end
            FETCH2: begin
                ivalid_c = 1'b1;
                iaddr_c  = {pc_word_inc, 2'b00};
                if (bus.iready) state_nxt = VALID;
            end
            VALID: if (decode_ready) state_nxt = WAIT_PC;
            default: state_nxt = FETCH1;
        endcase
    end

    // Reset drops the request in the same cycle it is asserted
    assign bus.ivalid  = ivalid_c && !reset;
    assign bus.iaddr   = iaddr_c;
    assign fetch_valid = (state == VALID);

    // State register
    always_ff @(posedge clock) begin
        if (reset) state <= FETCH1;
        else       state <= state_nxt;
    end

    // PC capture; only accepted while waiting for exec
    always_ff @(posedge clock) begin
        if (reset) begin
            pc_word <= RESET_VEC[31:2];
            pc_half <= RESET_VEC[1] & ENABLE_COMPRESSED;
        end else if (state == WAIT_PC && next_pc_valid) begin
            pc_word <= next_pc[31:2];
            pc_half <= next_pc[1] & ENABLE_COMPRESSED;
        end
    end

    // One-word buffer holds the most recently read bus word
    always_ff @(posedge clock) begin
        if (reset) begin
            buf_valid <= 1'b0;
            buf_tag   <= '0;
            buf_data  <= '0;
        end else if (state == FETCH1 && !buf_hit && bus.iready) begin
            buf_valid <= 1'b1;
            buf_tag   <= pc_word;
            buf_data  <= bus.idata;
        end else if (f2_done) begin
            buf_valid <= 1'b1;
            buf_tag   <= pc_word_inc;
            buf_data  <= bus.idata;
        end
    end

    // Instruction assembly for decode
    always_ff @(posedge clock) begin
        if (reset) begin
            instr   <= '0;
            instr_c <= 1'b0;
            hi_half <= '0;
        end else if (f1_done) begin
            if (is_c) begin
                instr   <= c_illegal ? 32'h0 : c_expanded;
                instr_c <= 1'b1;
            end else if (!pc_half) begin
                instr   <= word;
                instr_c <= 1'b0;
            end else begin
                hi_half <= half;
            end
        end else if (f2_done) begin
            instr   <= {bus.idata[15:0], hi_half};
            instr_c <= 1'b0;
        end
    end

endmodule

// File: tb/tb_fwrisc_fetch.sv
// Bench for fwrisc_fetch: vector table through a scoreboard, plus stall,
// reset-in-FETCH2 and compressed-disabled sequences.
module tb_fwrisc_fetch;

    logic        clock = 1'b0;
    logic        reset;
    logic [31:0] next_pc;
    logic        next_pc_valid;
    logic        fetch_valid;
    logic        decode_ready;
    logic [31:0] instr;
    logic        instr_c;
    logic        bus_rdy;

    logic [31:0] next_pc2;
    logic        next_pc_valid2;
    logic        fetch_valid2;
    logic        decode_ready2;
    logic [31:0] instr2;
    logic        instr_c2;

    logic [31:0] mem [256];

    fwrisc_fetch_if bus ();
    fwrisc_fetch_if bus2 ();

    assign bus.iready  = bus_rdy;
    assign bus.idata   = mem[bus.iaddr[9:2]];
    assign bus2.iready = bus_rdy;
    assign bus2.idata  = mem[bus2.iaddr[9:2]];

    fwrisc_fetch dut (
        .clock(clock), .reset(reset), .next_pc(next_pc), .next_pc_valid(next_pc_valid),
        .bus(bus), .fetch_valid(fetch_valid), .decode_ready(decode_ready),
        .instr(instr), .instr_c(instr_c)
    );

    fwrisc_fetch #(.ENABLE_COMPRESSED(1'b0)) dut_nc (
        .clock(clock), .reset(reset), .next_pc(next_pc2), .next_pc_valid(next_pc_valid2),
        .bus(bus2), .fetch_valid(fetch_valid2), .decode_ready(decode_ready2),
        .instr(instr2), .instr_c(instr_c2)
    );

    always #5 clock = ~clock;

    int nreads = 0;
    int nreads2 = 0;
    always @(posedge clock) if (bus.ivalid && bus.iready) nreads <= nreads + 1;
    always @(posedge clock) if (bus2.ivalid && bus2.iready) nreads2 <= nreads2 + 1;

    typedef struct {
        logic [31:0] instr;
        logic        c;
    } exp_t;
    exp_t sbq[$];

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        c;
        int          reads;
        int          lat;
    } vec_t;
    vec_t vt[14];

    int asserts = 0;
    int fails = 0;
    int r0;

    function automatic logic [7:0] wi(input logic [31:0] a);
        return a[9:2];
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        asserts++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic push(input logic [31:0] i, input logic c);
        exp_t e;
        e.instr = i;
        e.c = c;
        sbq.push_back(e);
    endtask

    // Wait for fetch_valid, pop scoreboard and compare; optionally hold decode off
    task automatic collect(input string name, input int exp_lat, input int exp_reads,
                           input int reads0, input int hold);
        int lat;
        bit seen;
        exp_t e;
        lat = 0;
        seen = 1'b0;
        while (!seen && lat < 40) begin
            @(negedge clock);
            next_pc_valid = 1'b0;
            #1;
            lat++;
            if (fetch_valid) seen = 1'b1;
        end
        check({name, " timeout"}, {31'b0, seen}, 32'd1);
        if (seen) begin
            if (sbq.size() == 0) begin
                check({name, " sb empty"}, 32'd0, 32'd1);
            end else begin
                e = sbq.pop_front();
                check({name, " instr"}, instr, e.instr);
                check({name, " instr_c"}, {31'b0, instr_c}, {31'b0, e.c});
            end
            if (exp_lat > 0) check({name, " latency"}, lat, exp_lat);
            check({name, " reads"}, nreads - reads0, exp_reads);
            check({name, " ivalid in VALID"}, {31'b0, bus.ivalid}, 32'd0);
            if (hold > 0) begin
                decode_ready = 1'b0;
                repeat (hold) begin
                    @(negedge clock); #1;
                    check({name, " hold fv"}, {31'b0, fetch_valid}, 32'd1);
                    check({name, " hold instr"}, instr, e.instr);
                end
                decode_ready = 1'b1;
            end
            @(negedge clock); #1;
            check({name, " fv drop"}, {31'b0, fetch_valid}, 32'd0);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 32'h0000_0013;
        mem[wi(32'h000)] = 32'h0000_0537;
        mem[wi(32'h100)] = 32'h4505_4501;
        mem[wi(32'h110)] = 32'h952E_4512;
        mem[wi(32'h120)] = 32'hC10C_C001;
        mem[wi(32'h130)] = 32'h8C05_6505;
        mem[wi(32'h140)] = 32'h1234_5677;
        mem[wi(32'h200)] = 32'h0537_1234;
        mem[wi(32'h204)] = 32'hABCD_0000;
        mem[wi(32'h210)] = 32'h0537_1111;
        mem[wi(32'h300)] = 32'h4505_4501;
        mem[wi(32'h310)] = 32'h0041_8193;
        mem[wi(32'h3FC)] = 32'h0537_0000;

        vt[0]  = '{32'h0000_0100, 32'h0000_0513, 1'b1, 1, 2};
        vt[1]  = '{32'h0000_0102, 32'h0010_0513, 1'b1, 0, 2};
        vt[2]  = '{32'h0000_0202, 32'h0000_0537, 1'b0, 2, 3};
        vt[3]  = '{32'h0000_0204, 32'h0000_0000, 1'b1, 0, 2};
        vt[4]  = '{32'h0000_0206, 32'h5F20_006F, 1'b1, 0, 2};
        vt[5]  = '{32'h0000_0310, 32'h0041_8193, 1'b0, 1, 2};
        vt[6]  = '{32'h0000_0101, 32'h0000_0513, 1'b1, 1, 2};
        vt[7]  = '{32'h0000_0110, 32'h0041_2503, 1'b1, 1, 2};
        vt[8]  = '{32'h0000_0112, 32'h00B5_0533, 1'b1, 0, 2};
        vt[9]  = '{32'h0000_0120, 32'h0004_0063, 1'b1, 1, 2};
        vt[10] = '{32'h0000_0122, 32'h00B5_2023, 1'b1, 0, 2};
        vt[11] = '{32'h0000_0130, 32'h0000_1537, 1'b1, 1, 2};
        vt[12] = '{32'h0000_0132, 32'h4094_0433, 1'b1, 0, 2};
        vt[13] = '{32'hFFFF_FFFE, 32'h0537_0537, 1'b0, 2, 3};

        reset = 1'b1;
        next_pc = '0;
        next_pc_valid = 1'b0;
        decode_ready = 1'b1;
        bus_rdy = 1'b1;
        next_pc2 = '0;
        next_pc_valid2 = 1'b0;
        decode_ready2 = 1'b1;

        // Reset state and first fetch of the reset vector
        repeat (3) @(negedge clock);
        #1;
        check("rst ivalid", {31'b0, bus.ivalid}, 32'd0);
        check("rst fetch_valid", {31'b0, fetch_valid}, 32'd0);
        check("rst instr", instr, 32'h0);
        check("rst instr_c", {31'b0, instr_c}, 32'd0);
        @(negedge clock);
        reset = 1'b0;
        r0 = nreads;
        push(32'h0000_0537, 1'b0);
        #1;
        check("boot ivalid", {31'b0, bus.ivalid}, 32'd1);
        check("boot iaddr", bus.iaddr, 32'h8000_0000);
        collect("boot", 1, 1, r0, 0);

        // Vector table
        foreach (vt[i]) begin
            @(negedge clock);
            next_pc = vt[i].pc;
            next_pc_valid = 1'b1;
            r0 = nreads;
            push(vt[i].instr, vt[i].c);
            collect($sformatf("vec%0d", i), vt[i].lat, vt[i].reads, r0, 0);
        end

        // Bus stall of 5 cycles, then decode holds off for 2 cycles
        @(negedge clock);
        bus_rdy = 1'b0;
        next_pc = 32'h0000_0140;
        next_pc_valid = 1'b1;
        r0 = nreads;
        push(32'h1234_5677, 1'b0);
        for (int k = 0; k < 5; k++) begin
            @(negedge clock);
            next_pc_valid = 1'b0;
            #1;
            check("stall ivalid", {31'b0, bus.ivalid}, 32'd1);
            check("stall iaddr", bus.iaddr, 32'h0000_0140);
            check("stall fv", {31'b0, fetch_valid}, 32'd0);
        end
        bus_rdy = 1'b1;
        collect("stall", 1, 1, r0, 2);

        // Reset while FETCH2 is requesting the second word
        @(negedge clock);
        next_pc = 32'h0000_0212;
        next_pc_valid = 1'b1;
        @(negedge clock);
        next_pc_valid = 1'b0;
        @(negedge clock);
        bus_rdy = 1'b0;
        #1;
        check("f2 ivalid", {31'b0, bus.ivalid}, 32'd1);
        check("f2 iaddr", bus.iaddr, 32'h0000_0214);
        reset = 1'b1;
        #1;
        check("f2 rst ivalid", {31'b0, bus.ivalid}, 32'd0);
        @(negedge clock);
        #1;
        check("f2 rst fv", {31'b0, fetch_valid}, 32'd0);
        check("f2 rst instr", instr, 32'h0);
        reset = 1'b0;
        bus_rdy = 1'b1;
        r0 = nreads;
        push(32'h0000_0537, 1'b0);
        #1;
        check("f2 refetch ivalid", {31'b0, bus.ivalid}, 32'd1);
        check("f2 refetch iaddr", bus.iaddr, 32'h8000_0000);
        collect("f2 refetch", 1, 1, r0, 0);

        // Compressed support disabled: halfword PC reads only the aligned word
        repeat (3) @(negedge clock);
        next_pc2 = 32'h0000_0302;
        next_pc_valid2 = 1'b1;
        r0 = nreads2;
        @(negedge clock);
        next_pc_valid2 = 1'b0;
        #1;
        check("nc ivalid", {31'b0, bus2.ivalid}, 32'd1);
        check("nc iaddr", bus2.iaddr, 32'h0000_0300);
        @(negedge clock);
        #1;
        check("nc fv", {31'b0, fetch_valid2}, 32'd1);
        check("nc instr", instr2, 32'h4505_4501);
        check("nc instr_c", {31'b0, instr_c2}, 32'd0);
        @(negedge clock);
        #1;
        check("nc fv drop", {31'b0, fetch_valid2}, 32'd0);
        check("nc reads", nreads2 - r0, 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
        $finish;
    end

endmodule
